mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, number of words implemented (1..256).
REQ-003 SHALL have parameter WAIT, default 2, wait-state cycles per access (0..15).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  1  access request from the CPU core.
REQ-007 SHALL have port write  input  1  1 = write access, 0 = read access; sampled with req.
REQ-008 SHALL have port ins_addr  input  8  word address; sampled with req.
REQ-009 SHALL have port data_out  input  WORD_SIZE  write data from the core; sampled with req.
REQ-010 SHALL have port data_in  output  WORD_SIZE  read data to the core.
REQ-011 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-012 SHALL have port busy  output  1  high while an access is in progress (states WAIT, ACK).
REQ-013 SHALL have port err  output  1  address out of range; valid only while ack=1.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE, WAIT, ACK.
REQ-015 In IDLE with req=1 at a posedge, SHALL capture ins_addr, write and data_out into internal registers.
REQ-016 On capture, SHALL go to WAIT with the down-counter loaded to WAIT-1 when the wait feature is compiled in and WAIT>0; otherwise SHALL go directly to ACK.
REQ-017 In WAIT, SHALL decrement the counter each cycle and go to ACK on the edge where the counter is 0; total WAIT cycles SHALL equal WAIT.
REQ-018 With capture edge E0, ack SHALL be high for exactly the one cycle following edge E0+W (W = effective wait count); the FSM SHALL then return to IDLE.
REQ-019 Read: data_in SHALL equal mem[captured addr] during the ack cycle and SHALL hold that value until the next read completes.
REQ-020 Write: mem[captured addr] SHALL be updated on the edge that enters ACK; data_in SHALL be unchanged by writes.
REQ-021 If captured addr >= DEPTH, err SHALL be 1 during ack, a read SHALL return 0, and a write SHALL leave memory unchanged.
REQ-022 req, write, ins_addr and data_out SHALL be ignored while in WAIT or ACK; a req still high in the first IDLE cycle after ack SHALL start a new access.
REQ-023 A read of an address written by the immediately preceding access SHALL return the new data.
REQ-024 All addresses SHALL be treated as unsigned; there is no wrap-around past DEPTH-1.

Reset
REQ-025 While rst_n=0, SHALL force state=IDLE, counter=0, ack=0, busy=0, err=0, data_in=0, independent of clk.
REQ-026 Reset asserted mid-access SHALL abort it: no ack is issued, and a write not yet committed SHALL be discarded.
REQ-027 Memory contents SHALL NOT be altered by reset; at time zero every word SHALL be 0.

Configuration
REQ-028 Macro MEM_RESPONDER_WAIT_EN defined: the WAIT state and counter SHALL be built, and latency SHALL follow the WAIT parameter.
REQ-029 Macro MEM_RESPONDER_WAIT_EN undefined: the WAIT state and counter SHALL be absent, WAIT SHALL be ignored, and every access SHALL ack in the cycle after the capture edge.

Verification
REQ-030 Write 0x0000_00AA to addr 0x05, then read addr 0x05 -> data_in=0x0000_00AA at ack, err=0.
REQ-031 With the macro defined and WAIT=2, req at edge E0 -> ack high only in the cycle after E0+2; busy high for 3 cycles.
REQ-032 With the macro undefined, a read of addr 0x00 after reset -> ack in the cycle after E0, data_in=0.
REQ-033 With DEPTH=16, write 0x1234 to addr 0x20, then read it -> err=1 on both acks, read data_in=0.
REQ-034 Pull rst_n low during WAIT of a write of 0xFFFF to addr 0x03 -> no ack, busy=0, and a later read of 0x03 returns 0.
REQ-035 Hold req high continuously with a read of addr 0x01 -> one ack per W+2 cycles, with no accesses lost or duplicated.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Word memory that answers CPU requests with an ack pulse. Wait
//            states are built only when MEM_RESPONDER_WAIT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int WORD_SIZE = 32,
    parameter int DEPTH     = 256,
    parameter int WAIT      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 write,
    input  logic [7:0]           ins_addr,
    input  logic [WORD_SIZE-1:0] data_out,
    output logic [WORD_SIZE-1:0] data_in,
    output logic                 ack,
    output logic                 busy,
    output logic                 err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MEM_RESPONDER_WAIT_EN
    localparam int W_EFF = WAIT;
`else
    // WAIT has no effect in this build: every access acks one cycle after capture.
    localparam int W_EFF = 0 * WAIT;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             addr_q, addr_d;
    logic                   write_q, write_d;
    logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
    logic                   ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic [WORD_SIZE-1:0]   rdata_q, rdata_d;
`ifdef MEM_RESPONDER_WAIT_EN
    logic [3:0]             cnt_q, cnt_d;
`endif

    logic [WORD_SIZE-1:0]   mem_q [DEPTH] = '{default: '0};

    logic [7:0]             w_acc_addr;
    logic                   w_acc_write;
    logic [WORD_SIZE-1:0]   w_acc_wdata;
    logic                   w_in_range;
    logic [AW-1:0]          w_idx;
    logic                   w_enter_ack;

    // With no wait states the access completes on the capture edge itself,
    // so the live inputs are used instead of the capture registers.
    assign w_acc_addr  = (state_q == ST_IDLE) ? ins_addr : addr_q;
    assign w_acc_write = (state_q == ST_IDLE) ? write    : write_q;
    assign w_acc_wdata = (state_q == ST_IDLE) ? data_out : wdata_q;
    assign w_in_range  = ({1'b0, w_acc_addr} < 9'(DEPTH));
    assign w_idx       = w_acc_addr[AW-1:0];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        ack_d       = 1'b0;
        busy_d      = busy_q;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        w_enter_ack = 1'b0;
`ifdef MEM_RESPONDER_WAIT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (req) begin
                    addr_d  = ins_addr;
                    write_d = write;
                    wdata_d = data_out;
                    busy_d  = 1'b1;
                    if (W_EFF == 0) begin
                        w_enter_ack = 1'b1;
                    end
`ifdef MEM_RESPONDER_WAIT_EN
                    else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(W_EFF - 1);
                    end
`endif
                end
            end
`ifdef MEM_RESPONDER_WAIT_EN
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    w_enter_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            ST_ACK: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (w_enter_ack) begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
            busy_d  = 1'b1;
            err_d   = ~w_in_range;
            if (!w_acc_write) begin
                rdata_d = w_in_range ? mem_q[w_idx] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
`ifdef MEM_RESPONDER_WAIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef MEM_RESPONDER_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Storage is never cleared by reset; the rst_n gate only keeps an
    // access from committing while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && w_enter_ack && w_acc_write && w_in_range) begin
            mem_q[w_idx] <= w_acc_wdata;
        end
    end

    assign data_in = rdata_q;
    assign ack     = ack_q;
    assign busy    = busy_q;
    assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Scoreboard bench for mem_responder (DEPTH=16, WAIT=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int DEPTH = 16;
    localparam int WAITP = 2;
`ifdef MEM_RESPONDER_WAIT_EN
    localparam int W = WAITP;
`else
    localparam int W = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        write = 1'b0;
    logic [7:0]  ins_addr = '0;
    logic [31:0] data_out = '0;
    logic [31:0] data_in;
    logic        ack, busy, err;

    mem_responder #(.WORD_SIZE(32), .DEPTH(DEPTH), .WAIT(WAITP)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .write(write),
        .ins_addr(ins_addr), .data_out(data_out),
        .data_in(data_in), .ack(ack), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          busy_cnt = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] last_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (ack === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 64'(cyc), 64'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                chk("err", 64'(err), 64'(e.err));
                chk("data_in", 64'(data_in), 64'(e.data));
                chk("busy_at_ack", 64'(busy), 64'd1);
            end
        end
    end

    function automatic exp_t predict(input logic wr, input logic [7:0] a,
                                     input logic [31:0] d, input int c);
        exp_t e;
        logic inr;
        inr   = (a < 8'(DEPTH));
        e.cyc = c;
        e.err = ~inr;
        if (wr) begin
            e.data = last_rd;
            if (inr) model[a[3:0]] = d;
        end else begin
            e.data  = inr ? model[a[3:0]] : 32'h0;
            last_rd = e.data;
        end
        return e;
    endfunction

    task automatic access(input logic wr, input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; write = wr; ins_addr = a; data_out = d;
        @(posedge clk); #1;
        sb.push_back(predict(wr, a, d, cyc + W));
        req = 1'b0;
        repeat (W + 2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        #3;
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_data_in", 64'(data_in), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        access(1'b0, 8'h00, 32'h0);
        access(1'b1, 8'h05, 32'h0000_00AA);
        busy_cnt = 0;
        access(1'b0, 8'h05, 32'h0);
        chk("busy_cycles", 64'(busy_cnt), 64'(W + 1));

        access(1'b1, 8'h0F, 32'hDEAD_BEEF);
        access(1'b0, 8'h0F, 32'h0);
        access(1'b1, 8'h20, 32'h0000_1234);
        access(1'b0, 8'h20, 32'h0);
        access(1'b0, 8'hFF, 32'h0);
        access(1'b0, 8'h10, 32'h0);
        access(1'b0, 8'h00, 32'h0);
        access(1'b0, 8'h0F, 32'h0);

        // Back-to-back reads with req held high.
        access(1'b1, 8'h01, 32'h0000_1111);
        @(negedge clk);
        req = 1'b1; write = 1'b0; ins_addr = 8'h01;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) sb.push_back(predict(1'b0, 8'h01, 32'h0, cyc + W + k * (W + 2)));
        repeat (3 * (W + 2)) @(posedge clk);
        #1 req = 1'b0;
        repeat (W + 3) @(negedge clk);
        chk("b2b_outstanding", 64'(sb.size()), 64'd0);

        // Reset during a write access.
        @(negedge clk);
        req = 1'b1; write = 1'b1; ins_addr = 8'h03; data_out = 32'h0000_FFFF;
        @(posedge clk); #1;
        req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_ack", 64'(ack), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_data_in", 64'(data_in), 64'd0);
        last_rd = '0;
`ifndef MEM_RESPONDER_WAIT_EN
        model[3] = 32'h0000_FFFF;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_ack", 64'(sb.size()), 64'd0);

        access(1'b0, 8'h05, 32'h0);
        access(1'b0, 8'h03, 32'h0);
        repeat (4) @(negedge clk);
        chk("final_outstanding", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
